// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the DRAM command path: command encodings, scheduler
// state type and default geometry.
package dram_ctrl_pkg;

  localparam int DEF_NUM_OF_BANKS = 8;
  localparam int DEF_NUM_OF_ROWS  = 128;
  localparam int DEF_NUM_OF_COLS  = 8;
  localparam int DEF_T_REF        = 16;

  localparam int DRAM_BANK_W = $clog2(DEF_NUM_OF_BANKS);
  localparam int DRAM_ROW_W  = $clog2(DEF_NUM_OF_ROWS);
  localparam int DRAM_COL_W  = $clog2(DEF_NUM_OF_COLS);

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_ACT = 2'b00;
  localparam cmd_t CMD_RD  = 2'b01;
  localparam cmd_t CMD_WR  = 2'b10;
  localparam cmd_t CMD_PRE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE      = 3'd1,
    ST_ACT      = 3'd2,
    ST_RW       = 3'd3,
    ST_REF_PRE  = 3'd4,
    ST_REF_WAIT = 3'd5
  } state_t;

endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank open-row tracker: one valid bit and one row register per bank,
// looked up combinationally and updated on acknowledged ACT/PRE commands.
module dram_open_row_table
  import dram_ctrl_pkg::*;
#(
  parameter int  NUM_OF_BANKS = DEF_NUM_OF_BANKS,
  parameter int  ROW_W        = DRAM_ROW_W,
  localparam int BANK_W       = $clog2(NUM_OF_BANKS)
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [BANK_W-1:0]       lookup_bank_i,
  input  logic [ROW_W-1:0]        lookup_row_i,
  output logic                    hit_o,
  output logic                    open_o,
  input  logic [BANK_W-1:0]       upd_bank_i,
  input  logic [ROW_W-1:0]        upd_row_i,
  input  logic                    set_i,
  input  logic                    clear_i,
  input  logic                    clear_all_i,
  output logic [NUM_OF_BANKS-1:0] open_bank_mask_o
);

  logic [NUM_OF_BANKS-1:0] valid_q, valid_d;
  logic [ROW_W-1:0]        row_q [NUM_OF_BANKS];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    if (clear_all_i) begin
      valid_d = '0;
    end else begin
      if (clear_i) valid_d[upd_bank_i] = 1'b0;
      if (set_i)   valid_d[upd_bank_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_b) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // NOTE: row storage has no reset; an entry is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (set_i) row_q[upd_bank_i] <= upd_row_i;
  end

  assign open_o           = valid_q[lookup_bank_i];
  assign hit_o            = valid_q[lookup_bank_i] && (row_q[lookup_bank_i] == lookup_row_i);
  assign open_bank_mask_o = valid_q;

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Single-request DRAM command sequencer: issues PRE/ACT/RD/WR as needed against
// the open-row table, with refresh (precharge-all + wait) taking priority.
module dram_cmd_scheduler
  import dram_ctrl_pkg::*;
#(
  parameter int  NUM_OF_BANKS = DEF_NUM_OF_BANKS,
  parameter int  NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
  parameter int  NUM_OF_COLS  = DEF_NUM_OF_COLS,
  parameter int  T_REF        = DEF_T_REF,
  localparam int BANK_W       = $clog2(NUM_OF_BANKS),
  localparam int ROW_W        = $clog2(NUM_OF_ROWS),
  localparam int COL_W        = $clog2(NUM_OF_COLS),
  localparam int CNT_W        = (T_REF > 1) ? $clog2(T_REF) : 1
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [BANK_W-1:0]       req_bank,
  input  logic [ROW_W-1:0]        req_row,
  input  logic [COL_W-1:0]        req_col,
  input  logic                    refresh_flag,
  output logic                    refresh_ack,
  output logic                    cmd_req,
  input  logic                    cmd_ack,
  output logic [1:0]              cmd,
  output logic                    cmd_all,
  output logic [BANK_W-1:0]       cmd_bank,
  output logic [ROW_W-1:0]        cmd_row,
  output logic [COL_W-1:0]        cmd_col,
  output logic                    done,
  output logic                    busy,
  output logic [NUM_OF_BANKS-1:0] open_bank_mask
);

  state_t            state_q, state_d;
  logic              cmd_req_q, cmd_req_d;
  cmd_t              cmd_q, cmd_d;
  logic              cmd_all_q, cmd_all_d;
  logic [BANK_W-1:0] cmd_bank_q, cmd_bank_d;
  logic [ROW_W-1:0]  cmd_row_q, cmd_row_d;
  logic [COL_W-1:0]  cmd_col_q, cmd_col_d;
  logic              rw_q, rw_d;
  logic              done_q, done_d;
  logic              refresh_ack_q, refresh_ack_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic tbl_hit, tbl_open;
  logic cmd_fire;

  assign cmd_fire = cmd_req_q && cmd_ack;

  dram_open_row_table #(
    .NUM_OF_BANKS (NUM_OF_BANKS),
    .ROW_W        (ROW_W)
  ) u_table (
    .clk              (clk),
    .rst_b            (rst_b),
    .lookup_bank_i    (req_bank),
    .lookup_row_i     (req_row),
    .hit_o            (tbl_hit),
    .open_o           (tbl_open),
    .upd_bank_i       (cmd_bank_q),
    .upd_row_i        (cmd_row_q),
    .set_i            (cmd_fire && (cmd_q == CMD_ACT)),
    .clear_i          (cmd_fire && (cmd_q == CMD_PRE) && !cmd_all_q),
    .clear_all_i      (cmd_fire && (cmd_q == CMD_PRE) && cmd_all_q),
    .open_bank_mask_o (open_bank_mask)
  );

  // Gated by rst_b so no request can appear accepted while reset is held.
  assign req_ready = rst_b && (state_q == ST_IDLE) && !refresh_flag && !refresh_ack_q;

  always_comb begin
    state_d       = state_q;
    cmd_req_d     = cmd_req_q;
    cmd_d         = cmd_q;
    cmd_all_d     = cmd_all_q;
    cmd_bank_d    = cmd_bank_q;
    cmd_row_d     = cmd_row_q;
    cmd_col_d     = cmd_col_q;
    rw_d          = rw_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    refresh_ack_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The refresh_ack cycle masks refresh_flag so the source can drop it.
        if (refresh_flag && !refresh_ack_q) begin
          if (|open_bank_mask) begin
            state_d    = ST_REF_PRE;
            cmd_req_d  = 1'b1;
            cmd_d      = CMD_PRE;
            cmd_all_d  = 1'b1;
            cmd_bank_d = '0;
            cmd_row_d  = '0;
            cmd_col_d  = '0;
          end else begin
            state_d = ST_REF_WAIT;
            cnt_d   = CNT_W'(T_REF - 1);
          end
        end else if (req_valid && req_ready) begin
          // The captured request stays on cmd_bank/row/col for every command it needs.
          cmd_req_d  = 1'b1;
          cmd_all_d  = 1'b0;
          cmd_bank_d = req_bank;
          cmd_row_d  = req_row;
          cmd_col_d  = req_col;
          rw_d       = req_rw;
          if (tbl_hit) begin
            state_d = ST_RW;
            cmd_d   = req_rw ? CMD_WR : CMD_RD;
          end else if (!tbl_open) begin
            state_d = ST_ACT;
            cmd_d   = CMD_ACT;
          end else begin
            state_d = ST_PRE;
            cmd_d   = CMD_PRE;
          end
        end
      end
      ST_PRE: begin
        if (cmd_fire) begin
          state_d = ST_ACT;
          cmd_d   = CMD_ACT;
        end
      end
      ST_ACT: begin
        if (cmd_fire) begin
          state_d = ST_RW;
          cmd_d   = rw_q ? CMD_WR : CMD_RD;
        end
      end
      ST_RW: begin
        if (cmd_fire) begin
          state_d   = ST_IDLE;
          cmd_req_d = 1'b0;
          done_d    = 1'b1;
        end
      end
      ST_REF_PRE: begin
        if (cmd_fire) begin
          state_d   = ST_REF_WAIT;
          cmd_req_d = 1'b0;
          cmd_all_d = 1'b0;
          cnt_d     = CNT_W'(T_REF - 1);
        end
      end
      ST_REF_WAIT: begin
        if (cnt_q == '0) begin
          state_d       = ST_IDLE;
          refresh_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cmd_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= ST_IDLE;
      cmd_req_q     <= 1'b0;
      cmd_q         <= CMD_ACT;
      cmd_all_q     <= 1'b0;
      cmd_bank_q    <= '0;
      cmd_row_q     <= '0;
      cmd_col_q     <= '0;
      rw_q          <= 1'b0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      refresh_ack_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_req_q     <= cmd_req_d;
      cmd_q         <= cmd_d;
      cmd_all_q     <= cmd_all_d;
      cmd_bank_q    <= cmd_bank_d;
      cmd_row_q     <= cmd_row_d;
      cmd_col_q     <= cmd_col_d;
      rw_q          <= rw_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      refresh_ack_q <= refresh_ack_d;
    end
  end

  assign cmd_req     = cmd_req_q;
  assign cmd         = cmd_q;
  assign cmd_all     = cmd_all_q;
  assign cmd_bank    = cmd_bank_q;
  assign cmd_row     = cmd_row_q;
  assign cmd_col     = cmd_col_q;
  assign done        = done_q;
  assign refresh_ack = refresh_ack_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler: hit/closed/conflict sequencing,
// ack stalls, refresh priority and reset abort, against hand-computed values.
module tb_dram_cmd_scheduler;
  import dram_ctrl_pkg::*;

  logic                   clk;
  logic                   rst_b;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_rw;
  logic [DRAM_BANK_W-1:0] req_bank;
  logic [DRAM_ROW_W-1:0]  req_row;
  logic [DRAM_COL_W-1:0]  req_col;
  logic                   refresh_flag;
  logic                   refresh_ack;
  logic                   cmd_req;
  logic                   cmd_ack;
  logic [1:0]             cmd;
  logic                   cmd_all;
  logic [DRAM_BANK_W-1:0] cmd_bank;
  logic [DRAM_ROW_W-1:0]  cmd_row;
  logic [DRAM_COL_W-1:0]  cmd_col;
  logic                   done;
  logic                   busy;
  logic [7:0]             open_bank_mask;

  int vectors     = 0;
  int miscompares = 0;

  // Log of acknowledged commands for the last request run through do_req.
  logic [1:0]             lg_cmd  [8];
  logic [DRAM_BANK_W-1:0] lg_bank [8];
  logic [DRAM_ROW_W-1:0]  lg_row  [8];
  logic [DRAM_COL_W-1:0]  lg_col  [8];
  logic                   lg_all  [8];
  int                     lg_cyc  [8];
  int                     n_cmd;
  int                     done_cyc;

  dram_cmd_scheduler dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rw         (req_rw),
    .req_bank       (req_bank),
    .req_row        (req_row),
    .req_col        (req_col),
    .refresh_flag   (refresh_flag),
    .refresh_ack    (refresh_ack),
    .cmd_req        (cmd_req),
    .cmd_ack        (cmd_ack),
    .cmd            (cmd),
    .cmd_all        (cmd_all),
    .cmd_bank       (cmd_bank),
    .cmd_row        (cmd_row),
    .cmd_col        (cmd_col),
    .done           (done),
    .busy           (busy),
    .open_bank_mask (open_bank_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one request with cmd_ack high, logs every acked command with the
  // cycle it was issued in (accept edge = cycle 0) and the cycle done pulses.
  task automatic do_req(input logic rw, input logic [DRAM_BANK_W-1:0] b,
                        input logic [DRAM_ROW_W-1:0] r, input logic [DRAM_COL_W-1:0] c);
    for (int i = 0; i < 8; i++) begin
      lg_cmd[i] = 'x; lg_bank[i] = 'x; lg_row[i] = 'x; lg_col[i] = 'x; lg_all[i] = 1'bx;
      lg_cyc[i] = -1;
    end
    n_cmd    = 0;
    done_cyc = -1;
    cmd_ack  = 1'b1;
    req_valid = 1'b1; req_rw = rw; req_bank = b; req_row = r; req_col = c;
    next_cycle();
    req_valid = 1'b0;
    for (int cy = 1; cy < 20; cy++) begin
      if (done) begin
        done_cyc = cy;
        break;
      end
      if (cmd_req && cmd_ack && n_cmd < 8) begin
        lg_cmd[n_cmd] = cmd; lg_bank[n_cmd] = cmd_bank; lg_row[n_cmd] = cmd_row;
        lg_col[n_cmd] = cmd_col; lg_all[n_cmd] = cmd_all; lg_cyc[n_cmd] = cy;
        n_cmd++;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_bank = '0; req_row = '0; req_col = '0;
    refresh_flag = 1'b0; cmd_ack = 1'b1;
    next_cycle();
    next_cycle();
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready: got %0b expected 0", req_ready); end
    vectors++; if ({cmd_req, cmd, cmd_all, done, busy, refresh_ack} !== 7'b0) begin miscompares++;
      $display("FAIL rst_outputs: got req=%0b cmd=%0d all=%0b done=%0b busy=%0b rack=%0b expected all 0",
               cmd_req, cmd, cmd_all, done, busy, refresh_ack); end
    vectors++; if (open_bank_mask !== 8'h00) begin miscompares++; $display("FAIL rst_mask: got %0h expected 00", open_bank_mask); end
    rst_b = 1'b1;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready: got %0b expected 1", req_ready); end
  endtask

  task automatic test_closed_read();
    do_req(1'b0, 3'd2, 7'd5, 3'd3);
    vectors++; if (n_cmd !== 2) begin miscompares++; $display("FAIL closed_ncmd: got %0d expected 2", n_cmd); end
    vectors++; if (lg_cmd[0] !== CMD_ACT || lg_bank[0] !== 3'd2 || lg_row[0] !== 7'd5 || lg_cyc[0] !== 1) begin miscompares++;
      $display("FAIL closed_act: got cmd=%0d bank=%0d row=%0d cyc=%0d expected cmd=0 bank=2 row=5 cyc=1",
               lg_cmd[0], lg_bank[0], lg_row[0], lg_cyc[0]); end
    vectors++; if (lg_cmd[1] !== CMD_RD || lg_bank[1] !== 3'd2 || lg_col[1] !== 3'd3 || lg_cyc[1] !== 2) begin miscompares++;
      $display("FAIL closed_rd: got cmd=%0d bank=%0d col=%0d cyc=%0d expected cmd=1 bank=2 col=3 cyc=2",
               lg_cmd[1], lg_bank[1], lg_col[1], lg_cyc[1]); end
    vectors++; if (done_cyc !== 3) begin miscompares++; $display("FAIL closed_done_cyc: got %0d expected 3", done_cyc); end
    vectors++; if (open_bank_mask !== 8'h04) begin miscompares++; $display("FAIL closed_mask: got %0h expected 04", open_bank_mask); end
    vectors++; if (cmd_req !== 1'b0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL closed_idle: got cmd_req=%0b busy=%0b expected 0 0", cmd_req, busy); end
    next_cycle();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width: got %0b expected 0", done); end
  endtask

  task automatic test_hit_write();
    do_req(1'b1, 3'd2, 7'd5, 3'd7);
    vectors++; if (n_cmd !== 1) begin miscompares++; $display("FAIL hit_ncmd: got %0d expected 1", n_cmd); end
    vectors++; if (lg_cmd[0] !== CMD_WR || lg_bank[0] !== 3'd2 || lg_col[0] !== 3'd7 || lg_cyc[0] !== 1) begin miscompares++;
      $display("FAIL hit_wr: got cmd=%0d bank=%0d col=%0d cyc=%0d expected cmd=2 bank=2 col=7 cyc=1",
               lg_cmd[0], lg_bank[0], lg_col[0], lg_cyc[0]); end
    vectors++; if (done_cyc !== 2) begin miscompares++; $display("FAIL hit_done_cyc: got %0d expected 2", done_cyc); end
  endtask

  task automatic test_conflict();
    do_req(1'b0, 3'd2, 7'd9, 3'd0);
    vectors++; if (n_cmd !== 3) begin miscompares++; $display("FAIL conf_ncmd: got %0d expected 3", n_cmd); end
    vectors++; if (lg_cmd[0] !== CMD_PRE || lg_bank[0] !== 3'd2 || lg_all[0] !== 1'b0 || lg_cyc[0] !== 1) begin miscompares++;
      $display("FAIL conf_pre: got cmd=%0d bank=%0d all=%0b cyc=%0d expected cmd=3 bank=2 all=0 cyc=1",
               lg_cmd[0], lg_bank[0], lg_all[0], lg_cyc[0]); end
    vectors++; if (lg_cmd[1] !== CMD_ACT || lg_bank[1] !== 3'd2 || lg_row[1] !== 7'd9 || lg_cyc[1] !== 2) begin miscompares++;
      $display("FAIL conf_act: got cmd=%0d bank=%0d row=%0d cyc=%0d expected cmd=0 bank=2 row=9 cyc=2",
               lg_cmd[1], lg_bank[1], lg_row[1], lg_cyc[1]); end
    vectors++; if (lg_cmd[2] !== CMD_RD || lg_cyc[2] !== 3) begin miscompares++;
      $display("FAIL conf_rd: got cmd=%0d cyc=%0d expected cmd=1 cyc=3", lg_cmd[2], lg_cyc[2]); end
    vectors++; if (done_cyc !== 4) begin miscompares++; $display("FAIL conf_done_cyc: got %0d expected 4", done_cyc); end
    vectors++; if (open_bank_mask !== 8'h04) begin miscompares++; $display("FAIL conf_mask: got %0h expected 04", open_bank_mask); end
    // Row 9 must now be the open row of bank 2: a follow-up read is a pure hit.
    do_req(1'b0, 3'd2, 7'd9, 3'd4);
    vectors++; if (n_cmd !== 1 || lg_cmd[0] !== CMD_RD || done_cyc !== 2) begin miscompares++;
      $display("FAIL conf_row_updated: got ncmd=%0d cmd=%0d done_cyc=%0d expected 1 1 2", n_cmd, lg_cmd[0], done_cyc); end
  endtask

  task automatic test_ack_stall();
    int bad = 0;
    req_valid = 1'b1; req_rw = 1'b0; req_bank = 3'd2; req_row = 7'd9; req_col = 3'd1;
    cmd_ack = 1'b0;
    next_cycle();
    req_valid = 1'b0;
    for (int cy = 1; cy <= 4; cy++) begin
      if (cy == 4) cmd_ack = 1'b1;
      if (cmd_req !== 1'b1 || cmd !== CMD_RD || cmd_bank !== 3'd2 || cmd_row !== 7'd9 ||
          cmd_col !== 3'd1 || done !== 1'b0) bad++;
      next_cycle();
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", bad); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stall_done_cyc5: got %0b expected 1", done); end
  endtask

  task automatic test_refresh_mid();
    int wait_cycles = 0;
    int ready_seen  = 0;
    do_req(1'b0, 3'd0, 7'd3, 3'd0);
    vectors++; if (open_bank_mask !== 8'h05) begin miscompares++; $display("FAIL ref_pre_mask: got %0h expected 05", open_bank_mask); end
    req_valid = 1'b1; req_rw = 1'b1; req_bank = 3'd0; req_row = 7'd3; req_col = 3'd5;
    next_cycle();
    req_valid = 1'b0;
    refresh_flag = 1'b1;
    vectors++; if (cmd_req !== 1'b1 || cmd !== CMD_WR) begin miscompares++;
      $display("FAIL ref_txn_first: got req=%0b cmd=%0d expected 1 2", cmd_req, cmd); end
    next_cycle();
    vectors++; if (done !== 1'b1 || req_ready !== 1'b0) begin miscompares++;
      $display("FAIL ref_txn_done: got done=%0b ready=%0b expected 1 0", done, req_ready); end
    next_cycle();
    vectors++; if (cmd_req !== 1'b1 || cmd !== CMD_PRE || cmd_all !== 1'b1 || cmd_bank !== 3'd0 ||
                   cmd_row !== 7'd0 || cmd_col !== 3'd0) begin miscompares++;
      $display("FAIL ref_pre_all: got req=%0b cmd=%0d all=%0b b=%0d r=%0d c=%0d expected 1 3 1 0 0 0",
               cmd_req, cmd, cmd_all, cmd_bank, cmd_row, cmd_col); end
    next_cycle();
    for (int i = 0; i < 40 && !refresh_ack; i++) begin
      if (busy && !cmd_req && open_bank_mask == 8'h00) wait_cycles++;
      if (req_ready) ready_seen++;
      next_cycle();
    end
    vectors++; if (wait_cycles !== 16) begin miscompares++; $display("FAIL ref_wait_len: got %0d expected 16", wait_cycles); end
    vectors++; if (ready_seen !== 0) begin miscompares++; $display("FAIL ref_ready_low: got %0d ready cycles expected 0", ready_seen); end
    vectors++; if (refresh_ack !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b0 || open_bank_mask !== 8'h00) begin miscompares++;
      $display("FAIL ref_ack_cycle: got ack=%0b busy=%0b ready=%0b mask=%0h expected 1 0 0 00",
               refresh_ack, busy, req_ready, open_bank_mask); end
    // Flag is still high through the ack cycle; it must be ignored there.
    next_cycle();
    vectors++; if (refresh_ack !== 1'b0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL ref_flag_ignored: got ack=%0b busy=%0b expected 0 0", refresh_ack, busy); end
    refresh_flag = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ref_ready_back: got %0b expected 1", req_ready); end
  endtask

  task automatic test_refresh_closed();
    int busy_cycles = 0;
    int req_seen    = 0;
    refresh_flag = 1'b1;
    next_cycle();
    for (int i = 0; i < 40 && !refresh_ack; i++) begin
      if (busy) busy_cycles++;
      if (cmd_req) req_seen++;
      next_cycle();
    end
    refresh_flag = 1'b0;
    vectors++; if (busy_cycles !== 16 || req_seen !== 0 || refresh_ack !== 1'b1) begin miscompares++;
      $display("FAIL ref_closed: got busy=%0d cmd_req_cycles=%0d ack=%0b expected 16 0 1", busy_cycles, req_seen, refresh_ack); end
    next_cycle();
  endtask

  task automatic test_reset_abort();
    int bad = 0;
    do_req(1'b0, 3'd1, 7'd2, 3'd0);
    vectors++; if (open_bank_mask !== 8'h02) begin miscompares++; $display("FAIL abort_pre_mask: got %0h expected 02", open_bank_mask); end
    cmd_ack = 1'b0;
    req_valid = 1'b1; req_rw = 1'b0; req_bank = 3'd4; req_row = 7'd1; req_col = 3'd0;
    next_cycle();
    req_valid = 1'b0;
    vectors++; if (cmd_req !== 1'b1 || cmd !== CMD_ACT) begin miscompares++;
      $display("FAIL abort_act_pending: got req=%0b cmd=%0d expected 1 0", cmd_req, cmd); end
    #2 rst_b = 1'b0;
    #1;
    vectors++; if (cmd_req !== 1'b0 || open_bank_mask !== 8'h00 || busy !== 1'b0 || req_ready !== 1'b0) begin miscompares++;
      $display("FAIL abort_async: got req=%0b mask=%0h busy=%0b ready=%0b expected 0 00 0 0",
               cmd_req, open_bank_mask, busy, req_ready); end
    next_cycle();
    next_cycle();
    rst_b = 1'b1;
    cmd_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done || refresh_ack || cmd_req) bad++;
      next_cycle();
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d bad cycles expected 0", bad); end
    do_req(1'b0, 3'd1, 7'd2, 3'd0);
    vectors++; if (n_cmd !== 2 || lg_cmd[0] !== CMD_ACT || done_cyc !== 3) begin miscompares++;
      $display("FAIL abort_table_cleared: got ncmd=%0d cmd=%0d done_cyc=%0d expected 2 0 3", n_cmd, lg_cmd[0], done_cyc); end
  endtask

  initial begin
    test_reset();
    test_closed_read();
    test_hit_write();
    test_conflict();
    test_ack_stall();
    test_refresh_mid();
    test_refresh_closed();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Sequences DRAM commands for one request at a time on the controller's cmd_req/cmd_ack command interface.
- Keeps a per-bank open-row table and issues only the needed commands for each request:
  - row hit: RD/WR only;
  - bank closed: ACT then RD/WR;
  - row conflict: PRE, then ACT, then RD/WR.
- Gives priority to refresh requests from the refresh counter; a refresh closes all banks before the refresh interval runs.

Parameters:
NUM_OF_BANKS, 8, bank count; BANK_W = clog2(NUM_OF_BANKS) = 3
NUM_OF_ROWS, 128, rows per bank; ROW_W = clog2(NUM_OF_ROWS) = 7
NUM_OF_COLS, 8, columns per row; COL_W = clog2(NUM_OF_COLS) = 3
T_REF, 16, number of cycles spent in refresh wait (must be ≥1)

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted on the edge where req_valid && req_ready
req_rw  in  1  1 = write, 0 = read
req_bank  in  BANK_W  target bank
req_row  in  ROW_W  target row
req_col  in  COL_W  target column
refresh_flag  in  1  level refresh request
refresh_ack  out  1  one-cycle pulse when refresh completes
cmd_req  out  1  command valid; held until acknowledged
cmd_ack  in  1  command accepted on the edge where cmd_req && cmd_ack
cmd  out  2  00 ACT, 01 RD, 10 WR, 11 PRE
cmd_all  out  1  qualifies PRE as precharge-all
cmd_bank  out  BANK_W  command bank
cmd_row  out  ROW_W  command row
cmd_col  out  COL_W  command column
done  out  1  one-cycle pulse after RD/WR acknowledged
busy  out  1  state != IDLE
open_bank_mask  out  NUM_OF_BANKS  open-row valid bit per bank

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset:
  - state goes to IDLE and the table is cleared;
  - all outputs are 0, except req_ready, which follows its equation (0 while rst_b is low).
  - Reset asserted mid-command drops cmd_req immediately. No done or refresh_ack is produced for the aborted work.
- req_ready is combinational: (state == IDLE) && !refresh_flag && !refresh_ack.
- States: IDLE, PRE, ACT, RW, REF_PRE, REF_WAIT. All command outputs are registered.
- IDLE:
  - refresh_flag has priority over a request.
  - If any bank is open, go to REF_PRE; otherwise go to REF_WAIT.
  - Else, on accept, capture the request and branch on a table lookup of req_bank:
    - hit goes to RW;
    - closed goes to ACT;
    - conflict goes to PRE.
- Command states:
  - cmd_req = 1 and cmd/bank/row/col are stable until the ack edge.
  - PRE (single bank) goes to ACT.
  - ACT goes to RW.
  - RW goes to IDLE, with done = 1 in the following cycle.
- Latency, counted from the accept edge (cycle 0), with cmd_ack tied to 1:
  - cmd_req is high from cycle 1;
  - hit: done in cycle 2;
  - closed: done in cycle 3;
  - conflict: done in cycle 4.
  - Each cycle of ack delay adds one cycle to these numbers.
- Table updates, on the ack edge:
  - ACT sets valid[bank] = 1 and row[bank] = cmd_row;
  - single-bank PRE clears valid[bank];
  - PRE with cmd_all clears all entries.
- A refresh_flag that rises mid-transaction waits until the request completes (back in IDLE).
- REF_PRE: cmd = 11, cmd_all = 1, bank/row/col = 0. On ack, go to REF_WAIT.
- REF_WAIT:
  - cmd_req = 0; the counter loads T_REF-1 and decrements to 0;
  - then return to IDLE with refresh_ack = 1 for one cycle.
- refresh_flag is ignored during the refresh_ack cycle, which lets the counter clear it.
- cmd_ack arriving while cmd_req = 0 is ignored.
- Requests to the same bank and row back-to-back hit without a new ACT.

Decomposition:
- Package dram_ctrl_pkg holds:
  - cmd encodings CMD_ACT, CMD_RD, CMD_WR, CMD_PRE;
  - the state enum;
  - width constants.
- Sub-module dram_open_row_table, built from per-bank valid/row registers:
  - lookup ports: hit, open;
  - update ports: set, clear, clear_all;
  - open_bank_mask output.

Test Plan:
- Reset, then read bank 2 row 5 col 3 with ack tied to 1 → ACT(b2, r5) in cycle 1, RD(b2, c3) in cycle 2, done in cycle 3, open_bank_mask = 8'h04.
- Then write bank 2 row 5 col 7 → single WR in cycle 1, done in cycle 2, no ACT issued.
- Then read bank 2 row 9 → PRE(b2), ACT(r9), RD; done in cycle 4; row[2] = 9.
- Hit request with cmd_ack delayed 3 cycles → cmd outputs held stable throughout, done 3 cycles later.
- Raise refresh_flag mid-transaction with banks 0 and 2 open → transaction completes first; then PRE with cmd_all = 1; after ack, 16 idle cycles; refresh_ack pulse; mask = 0; req_ready = 0 throughout.
- Assert rst_b low while ACT is pending → cmd_req = 0 immediately, mask = 0, no done.
